// File: rtl/wb_ctrl.sv
// -----------------------------------------------------------------------------
// wb_ctrl -- write-back sequencer for the 4-entry register group and its ZF
// register.
//
// ALU results arrive over a valid/ready handshake and are buffered in a small
// FIFO. The entry at the FIFO head is serialised into one-cycle register-enable
// strobes: first the destination register (if we), then the ZF register (if zf).
// The entry is popped, and wb_done pulses, on the edge after its last strobe.
// After every entry the sequencer spends one cycle in IDLE.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   wb_valid  in   result offered this cycle
//   wb_ready  out  FIFO can accept (registered count != DEPTH)
//   wb_rd     in   destination register index 0..3
//   wb_data   in   result value
//   wb_we     in   write wb_data to register wb_rd
//   wb_zf     in   update ZF register from wb_data
//   reg_en    out  one-hot write strobes; [3:0] = reg0..reg3, [4] = ZF
//   d_in      out  write data to the register group
//   wb_done   out  one-cycle pulse when an entry retires
//   busy      out  FIFO non-empty or sequencer not IDLE
//   count     out  FIFO occupancy
// -----------------------------------------------------------------------------
module wb_ctrl #(
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [1:0]               wb_rd,
    input  logic [DW-1:0]            wb_data,
    input  logic                     wb_we,
    input  logic                     wb_zf,
    output logic [4:0]               reg_en,
    output logic [DW-1:0]            d_in,
    output logic                     wb_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_DATA = 2'd1;
    localparam logic [1:0] ST_WR_ZF   = 2'd2;

    localparam logic [4:0] ZF_STROBE  = 5'b10000;

    typedef struct packed {
        logic [1:0]    rd;
        logic [DW-1:0] data;
        logic          we;
        logic          zf;
    } wb_entry_t;

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    wb_entry_t         fifo_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    wb_entry_t         head;
    wb_entry_t         in_entry;
    logic              push;
    logic              pop;

    // Ready looks only at the registered occupancy, so a slot freed by this
    // cycle's pop is not offered until the next cycle.
    assign wb_ready = (count != CW'(DEPTH));
    assign push     = wb_valid && wb_ready;
    assign head     = fifo_mem[rd_ptr];

    assign in_entry.rd   = wb_rd;
    assign in_entry.data = wb_data;
    assign in_entry.we   = wb_we;
    assign in_entry.zf   = wb_zf;

    // Payload storage carries no reset; only the pointers and count define
    // which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Strobe sequencer
    // -------------------------------------------------------------------------
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [4:0]    reg_en_nxt;
    logic [DW-1:0] d_in_nxt;
    logic          done_nxt;
    logic [DW-1:0] zf_word;

    // ZF register stores 1 when the result is zero.
    assign zf_word = {{(DW-1){1'b0}}, (head.data == '0)};

    always_comb begin
        state_nxt  = state;
        reg_en_nxt = '0;
        d_in_nxt   = d_in;      // d_in holds between strobes
        done_nxt   = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    if (head.we) begin
                        state_nxt  = ST_WR_DATA;
                        reg_en_nxt = 5'b00001 << head.rd;
                        d_in_nxt   = head.data;
                    end else if (head.zf) begin
                        state_nxt  = ST_WR_ZF;
                        reg_en_nxt = ZF_STROBE;
                        d_in_nxt   = zf_word;
                    end else begin
                        // Nothing to write: retire straight from IDLE.
                        pop      = 1'b1;
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_WR_DATA: begin
                if (head.zf) begin
                    state_nxt  = ST_WR_ZF;
                    reg_en_nxt = ZF_STROBE;
                    d_in_nxt   = zf_word;
                end else begin
                    state_nxt = ST_IDLE;
                    pop       = 1'b1;
                    done_nxt  = 1'b1;
                end
            end
            ST_WR_ZF: begin
                state_nxt = ST_IDLE;
                pop       = 1'b1;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            reg_en  <= '0;
            d_in    <= '0;
            wb_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            reg_en  <= reg_en_nxt;
            d_in    <= d_in_nxt;
            wb_done <= done_nxt;
        end
    end

    assign busy = (count != '0) || (state != ST_IDLE);

endmodule

// File: tb/tb_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_ctrl -- self-checking bench for wb_ctrl.
// The reference model expands every accepted entry into its expected strobe
// list (data write, then ZF write) and tracks occupancy as accepted-retired.
// -----------------------------------------------------------------------------
module tb_wb_ctrl;
    localparam int DW    = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic          wb_ready;
    logic [1:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          wb_we;
    logic          wb_zf;
    logic [4:0]    reg_en;
    logic [DW-1:0] d_in;
    logic          wb_done;
    logic          busy;
    logic [CW-1:0] count;

    wb_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we), .wb_zf(wb_zf),
        .reg_en(reg_en), .d_in(d_in), .wb_done(wb_done), .busy(busy),
        .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]    en;
        logic [DW-1:0] d;
        int            cyc;
    } strobe_t;

    strobe_t obs_q[$];
    strobe_t exp_q[$];
    int      done_cyc_q[$];
    int      acc_total  = 0;
    int      done_total = 0;
    int      mon_err    = 0;
    int      onehot_err = 0;
    int      n_cmp      = 0;
    int      n_fail     = 0;

    // Observation log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (reg_en != 5'd0) begin
                strobe_t s;
                s.en = reg_en; s.d = d_in; s.cyc = cyc;
                obs_q.push_back(s);
                if (!$onehot(reg_en)) onehot_err++;
            end
            if (wb_done === 1'b1) begin
                done_total++;
                done_cyc_q.push_back(cyc);
            end
            if (count !== CW'(acc_total - done_total)) mon_err++;
            if (wb_ready !== ((acc_total - done_total) != DEPTH)) mon_err++;
        end
    end

    // Reference: an entry writes its register (if we) then ZF (if zf).
    task automatic model_push(input logic [1:0] rd, input logic [DW-1:0] data,
                              input logic we, input logic zf);
        strobe_t s;
        s.cyc = 0;
        if (we) begin
            s.en = 5'd1 << rd; s.d = data;
            exp_q.push_back(s);
        end
        if (zf) begin
            s.en = 5'b10000; s.d = (data == 0) ? 16'h0001 : 16'h0000;
            exp_q.push_back(s);
        end
    endtask

    // Call at/after a negedge; returns at the negedge after the accept edge,
    // with wb_valid still high.
    task automatic offer(input logic [1:0] rd, input logic [DW-1:0] data,
                         input logic we, input logic zf,
                         output int acc_cyc, output int waits);
        logic rdy;
        acc_cyc = -1;
        waits   = 0;
        wb_valid = 1'b1; wb_rd = rd; wb_data = data; wb_we = we; wb_zf = zf;
        for (int i = 0; i < 100; i++) begin
            rdy = wb_ready;
            @(posedge clk);
            if (rdy) begin
                acc_total++;
                model_push(rd, data, we, zf);
                @(negedge clk);
                acc_cyc = cyc;
                return;
            end
            @(negedge clk);
            waits++;
        end
        n_cmp++; n_fail++;
        $display("FAIL offer_timeout: wb_ready stayed %0b, required 1", wb_ready);
    endtask

    task automatic idle(input int n);
        wb_valid = 1'b0;
        wb_rd = 2'($urandom); wb_data = DW'($urandom);
        wb_we = 1'($urandom); wb_zf = 1'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        bit ok = 0;
        idle(0);
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b0) begin ok = 1; break; end
            idle(1);
        end
        idle(2);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%0b, required 0", busy);
        end
    endtask

    task automatic clear_logs();
        obs_q.delete(); exp_q.delete(); done_cyc_q.delete();
    endtask

    task automatic test_reset();
        int c0, w;
        rst = 1'b0; wb_valid = 1'b1;
        wb_rd = 2'd1; wb_data = 16'hBEEF; wb_we = 1'b1; wb_zf = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (reg_en !== 5'd0)   begin n_fail++; $display("FAIL rst_reg_en: got %b want 0", reg_en); end
        n_cmp++; if (d_in !== 16'd0)    begin n_fail++; $display("FAIL rst_d_in: got %h want 0", d_in); end
        n_cmp++; if (count !== '0)      begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (wb_done !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %b want 0", wb_done); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", wb_ready); end
        @(negedge clk);
        rst = 1'b1; wb_valid = 1'b0;
        idle(2);
        // Reset in the middle of a data write.
        offer(2'd3, 16'h5A5A, 1'b1, 1'b1, c0, w);
        idle(0);
        for (int i = 0; i < 5; i++) begin
            if (reg_en != 5'd0) break;
            @(negedge clk);
        end
        n_cmp++;
        if (reg_en !== 5'b01000) begin n_fail++; $display("FAIL mid_setup_strobe: got %b want 01000", reg_en); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (reg_en !== 5'd0) begin n_fail++; $display("FAIL mid_rst_reg_en: got %b want 0", reg_en); end
        n_cmp++; if (count !== '0)    begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        acc_total = 0; done_total = 0;
        clear_logs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(4);
        n_cmp++;
        if (obs_q.size() != 0 || done_cyc_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_rst_discard: strobes=%0d dones=%0d want 0/0", obs_q.size(), done_cyc_q.size());
        end
    endtask

    task automatic test_single_write();
        int c0, w;
        clear_logs();
        offer(2'd2, 16'h1234, 1'b1, 1'b0, c0, w);
        drain();
        n_cmp++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_nstrobe: got %0d want 1", obs_q.size()); end
        else begin
            n_cmp++;
            if (obs_q[0].en !== 5'b00100 || obs_q[0].d !== 16'h1234 || obs_q[0].cyc != c0 + 1) begin
                n_fail++;
                $display("FAIL single_strobe: got en=%b d=%h cyc=%0d want en=00100 d=1234 cyc=%0d",
                         obs_q[0].en, obs_q[0].d, obs_q[0].cyc, c0 + 1);
            end
        end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != c0 + 2) begin
            n_fail++;
            $display("FAIL single_done: got %0d pulses, want 1 at cyc %0d", done_cyc_q.size(), c0 + 2);
        end
    endtask

    task automatic test_write_zf();
        logic [DW-1:0] pats [2];
        logic [DW-1:0] zfs  [2];
        int c0, w;
        pats[0] = 16'h0000; zfs[0] = 16'h0001;
        pats[1] = 16'h00FF; zfs[1] = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            offer(2'd1, pats[k], 1'b1, 1'b1, c0, w);
            drain();
            n_cmp++;
            if (obs_q.size() != 2) begin n_fail++; $display("FAIL zf_nstrobe[%0d]: got %0d want 2", k, obs_q.size()); end
            else begin
                n_cmp++;
                if (obs_q[0].en !== 5'b00010 || obs_q[0].d !== pats[k] || obs_q[0].cyc != c0 + 1) begin
                    n_fail++;
                    $display("FAIL zf_data_strobe[%0d]: got en=%b d=%h cyc=%0d want en=00010 d=%h cyc=%0d",
                             k, obs_q[0].en, obs_q[0].d, obs_q[0].cyc, pats[k], c0 + 1);
                end
                n_cmp++;
                if (obs_q[1].en !== 5'b10000 || obs_q[1].d !== zfs[k] || obs_q[1].cyc != c0 + 2) begin
                    n_fail++;
                    $display("FAIL zf_flag_strobe[%0d]: got en=%b d=%h cyc=%0d want en=10000 d=%h cyc=%0d",
                             k, obs_q[1].en, obs_q[1].d, obs_q[1].cyc, zfs[k], c0 + 2);
                end
            end
            n_cmp++;
            if (done_cyc_q.size() != 1 || done_cyc_q[0] != c0 + 3) begin
                n_fail++;
                $display("FAIL zf_done[%0d]: got %0d pulses, want 1 at cyc %0d", k, done_cyc_q.size(), c0 + 3);
            end
        end
    endtask

    task automatic test_backpressure();
        int c0, w;
        logic [1:0] rds [3];
        rds[0] = 2'd0; rds[1] = 2'd3; rds[2] = 2'd1;
        clear_logs();
        offer(rds[0], DW'($urandom), 1'b1, 1'b0, c0, w);
        offer(rds[1], DW'($urandom), 1'b1, 1'b0, c0, w);
        n_cmp++;
        if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", wb_ready); end
        offer(rds[2], DW'($urandom), 1'b1, 1'b0, c0, w);
        n_cmp++;
        if (w < 1) begin n_fail++; $display("FAIL bp_third_held: waited %0d cycles, want >=1", w); end
        drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_nstrobe: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].en !== exp_q[i].en || obs_q[i].d !== exp_q[i].d) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got en=%b d=%h want en=%b d=%h",
                         i, obs_q[i].en, obs_q[i].d, exp_q[i].en, exp_q[i].d);
            end
        end
        n_cmp++;
        if (done_cyc_q.size() != 3) begin n_fail++; $display("FAIL bp_ndone: got %0d want 3", done_cyc_q.size()); end
    endtask

    task automatic test_simul_push_pop();
        int c0, c1, w;
        clear_logs();
        offer(2'd2, 16'hA001, 1'b1, 1'b0, c0, w);
        idle(1);
        offer(2'd0, 16'hB002, 1'b1, 1'b0, c1, w);
        n_cmp++;
        if (c1 != c0 + 2) begin n_fail++; $display("FAIL sim_accept_cyc: got %0d want %0d", c1, c0 + 2); end
        n_cmp++;
        if (count !== CW'(1)) begin n_fail++; $display("FAIL sim_count: got %0d want 1", count); end
        n_cmp++;
        if (wb_done !== 1'b1) begin n_fail++; $display("FAIL sim_done: got %b want 1", wb_done); end
        drain();
        n_cmp++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL sim_nstrobe: got %0d want 2", obs_q.size()); end
        else begin
            n_cmp++;
            if (obs_q[1].en !== 5'b00001 || obs_q[1].d !== 16'hB002 || obs_q[1].cyc != c1 + 1) begin
                n_fail++;
                $display("FAIL sim_second: got en=%b d=%h cyc=%0d want en=00001 d=b002 cyc=%0d",
                         obs_q[1].en, obs_q[1].d, obs_q[1].cyc, c1 + 1);
            end
        end
    endtask

    task automatic test_noop_and_zf_only();
        int c0, w;
        clear_logs();
        offer(2'd3, 16'h7777, 1'b0, 1'b0, c0, w);
        drain();
        n_cmp++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL noop_strobe: got %0d strobes want 0", obs_q.size()); end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != c0 + 1) begin
            n_fail++; $display("FAIL noop_done: got %0d pulses, want 1 at cyc %0d", done_cyc_q.size(), c0 + 1);
        end
        clear_logs();
        offer(2'd0, 16'h0000, 1'b0, 1'b1, c0, w);
        drain();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0].en !== 5'b10000 || obs_q[0].d !== 16'h0001 || obs_q[0].cyc != c0 + 1) begin
            n_fail++; $display("FAIL zfonly_strobe: got %0d strobes, want one en=10000 d=0001 at cyc %0d", obs_q.size(), c0 + 1);
        end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != c0 + 2) begin
            n_fail++; $display("FAIL zfonly_done: got %0d pulses, want 1 at cyc %0d", done_cyc_q.size(), c0 + 2);
        end
    endtask

    task automatic test_random();
        int c0, w;
        logic [DW-1:0] d;
        clear_logs();
        for (int n = 0; n < 40; n++) begin
            d = ($urandom_range(3) == 0) ? 16'h0000 : DW'($urandom);
            offer(2'($urandom), d, 1'($urandom), 1'($urandom), c0, w);
            idle($urandom_range(2));
        end
        drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rnd_nstrobe: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].en !== exp_q[i].en || obs_q[i].d !== exp_q[i].d) begin
                n_fail++;
                $display("FAIL rnd_strobe[%0d]: got en=%b d=%h want en=%b d=%h",
                         i, obs_q[i].en, obs_q[i].d, exp_q[i].en, exp_q[i].d);
            end
        end
        n_cmp++;
        if (done_cyc_q.size() != 40) begin n_fail++; $display("FAIL rnd_ndone: got %0d want 40", done_cyc_q.size()); end
    endtask

    initial begin
        rst = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; wb_we = 1'b0; wb_zf = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_write_zf();
        test_backpressure();
        test_simul_push_pop();
        test_noop_and_zf_only();
        test_random();
        n_cmp++;
        if (mon_err != 0) begin n_fail++; $display("FAIL occupancy_track: %0d cycles where count/wb_ready disagreed with accepted-retired", mon_err); end
        n_cmp++;
        if (onehot_err != 0) begin n_fail++; $display("FAIL reg_en_onehot: %0d multi-bit strobes, want 0", onehot_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
